// File: rtl/calc_display_if.sv
// calc_display_if: value/load request and busy/overflow/seg/an display bus of calc_display_driver.
interface calc_display_if #(
    parameter int DIGITS = 8
);
    logic [31:0]       value;
    logic              load;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    modport master (output value, load, input busy, overflow, seg, an);
    modport slave (input value, load, output busy, overflow, seg, an);
endinterface

// File: rtl/calc_display_driver.sv
// calc_display_driver: double-dabble signed-to-7-segment converter with continuous digit scan.
// Optional macro LZ_BLANK_EN: leading-zero blanking with a floating minus sign.
module calc_display_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input logic           clk,
    input logic           rst,
    calc_display_if.slave bus
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [6:0] BLANK = 7'b1111111, MINUS = 7'b0111111;
    localparam logic [6:0] LET_E = 7'b0000110, LET_R = 7'b0101111;
    typedef enum logic [1:0] {IDLE, ABS, SHIFT, FORMAT} state_t;
    state_t state, state_nx;
    logic ready, sign, fits;
    logic [31:0] val, mag;
    logic [39:0] bcd, bcd_adj;
    logic [4:0] bit_cnt;
    logic [3:0] n;
    logic [6:0] digit [DIGITS];
    logic [6:0] img [DIGITS];
    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] idx;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = (bus.load && ready) ? ABS : IDLE;
            ABS:    state_nx = SHIFT;
            SHIFT:  state_nx = (bit_cnt == 5'd31) ? FORMAT : SHIFT;
            FORMAT: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // n counts significant decimal digits; zero still occupies one
    always_comb begin
        n = 4'd1;
        for (int i = 1; i < 10; i++)
            if (bcd[4*i +: 4] != 4'd0) n = 4'(i + 1);
        fits = sign ? (int'(n) + 1 <= DIGITS) : (int'(n) <= DIGITS);
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) img[i] = BLANK;
        if (!fits) begin
            img[2] = LET_E;
            img[1] = LET_R;
            img[0] = LET_R;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
`ifdef LZ_BLANK_EN
                if (i < int'(n)) img[i] = seg_code(bcd[4*i +: 4]);
                else if (sign && i == int'(n)) img[i] = MINUS;
`else
                img[i] = (sign && i == DIGITS - 1) ? MINUS : seg_code(bcd[4*i +: 4]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ready        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.overflow <= 1'b0;
            sign         <= 1'b0;
            val          <= '0;
            mag          <= '0;
            bcd          <= '0;
            bit_cnt      <= '0;
            for (int i = 0; i < DIGITS; i++) digit[i] <= BLANK;
        end else begin
            state    <= state_nx;
            ready    <= 1'b1;
            bus.busy <= state != IDLE;
            if (state == IDLE && state_nx == ABS) val <= bus.value;
            if (state == ABS) begin
                sign    <= val[31];
                mag     <= val[31] ? -val : val;
                bcd     <= '0;
                bit_cnt <= '0;
            end
            if (state == SHIFT) begin
                {bcd, mag} <= {bcd_adj[38:0], mag, 1'b0};
                bit_cnt    <= bit_cnt + 5'd1;
            end
            if (state == FORMAT) begin
                digit        <= img;
                bus.overflow <= !fits;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            bus.an   <= '1;
            bus.seg  <= BLANK;
        end else begin
            scan_cnt <= (scan_cnt == CW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
            if (scan_cnt == CW'(SCAN_DIV - 1)) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            bus.an  <= ~(DIGITS'(1) << idx);
            bus.seg <= digit[idx];
        end
    end
endmodule
